// File: rtl/protectlib_result_sel.sv
// Per-channel combo/seq result selector: each channel shows its most recently stamped candidate, with a saturating shared stamp counter.
// Latency: 1 cycle from strobe to out_*; no backpressure, so every strobe is accepted on the edge.
module protectlib_result_sel #(
    parameter int DATA_W  = 32,
    parameter int NUM_OUT = 1,
    parameter int SEQ_W   = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        combo_valid,
    input  logic [NUM_OUT-1:0]          combo_mask,
    input  logic [NUM_OUT*DATA_W-1:0]   combo_data,
    input  logic                        seq_valid,
    input  logic [NUM_OUT-1:0]          seq_mask,
    input  logic [NUM_OUT*DATA_W-1:0]   seq_data,
    output logic [NUM_OUT*DATA_W-1:0]   out_data,
    output logic [NUM_OUT-1:0]          out_src,
    output logic [NUM_OUT*SEQ_W-1:0]    out_stamp,
    output logic [SEQ_W-1:0]            seqnum,
    output logic                        seq_sat
);

    typedef struct packed {
        logic [SEQ_W-1:0]  stamp;
        logic [DATA_W-1:0] data;
    } cand_t;

    localparam logic [SEQ_W-1:0] SEQ_MAX = '1;

    logic [SEQ_W:0]   sum_one;
    logic [SEQ_W:0]   sum_two;
    logic [SEQ_W-1:0] stamp_c;
    logic [SEQ_W-1:0] stamp_s;
    logic [SEQ_W-1:0] seqnum_nxt;

    // One extra bit catches the carry so both increments clamp at SEQ_MAX.
    assign sum_one = {1'b0, seqnum} + {{SEQ_W{1'b0}}, 1'b1};
    assign sum_two = {1'b0, seqnum} + {{(SEQ_W-1){1'b0}}, 2'd2};

    always_comb begin
        stamp_c    = sum_one[SEQ_W] ? SEQ_MAX : sum_one[SEQ_W-1:0];
        stamp_s    = stamp_c;
        seqnum_nxt = seqnum;
        if (combo_valid) begin
            seqnum_nxt = stamp_c;
        end
        if (seq_valid) begin
            if (combo_valid) begin
                stamp_s = sum_two[SEQ_W] ? SEQ_MAX : sum_two[SEQ_W-1:0];
            end
            seqnum_nxt = stamp_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seqnum  <= '0;
            seq_sat <= 1'b0;
        end else begin
            seqnum <= seqnum_nxt;
            if (seqnum_nxt == SEQ_MAX) begin
                seq_sat <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_ch
        cand_t combo_q;
        cand_t seq_q;
        logic  last_wr;
        logic  sel_seq;

        always_ff @(posedge clk) begin
            if (rst) begin
                combo_q <= '0;
                seq_q   <= '0;
                last_wr <= 1'b0;
            end else begin
                if (combo_valid && combo_mask[i]) begin
                    combo_q <= '{stamp: stamp_c, data: combo_data[i*DATA_W +: DATA_W]};
                    last_wr <= 1'b0;
                end
                // Seq is the later event of a simultaneous pair, so it owns last_wr.
                if (seq_valid && seq_mask[i]) begin
                    seq_q   <= '{stamp: stamp_s, data: seq_data[i*DATA_W +: DATA_W]};
                    last_wr <= 1'b1;
                end
            end
        end

        // Equal non-zero stamps only occur once saturated; last writer breaks the tie.
        assign sel_seq = (seq_q.stamp > combo_q.stamp) ||
                         ((seq_q.stamp == combo_q.stamp) && (seq_q.stamp != '0) && last_wr);

        assign out_data[i*DATA_W +: DATA_W] = sel_seq ? seq_q.data  : combo_q.data;
        assign out_stamp[i*SEQ_W +: SEQ_W]  = sel_seq ? seq_q.stamp : combo_q.stamp;
        assign out_src[i]                   = sel_seq;
    end

endmodule
